// File: rtl/dcache_bank_ctrl.sv
// Port sequencer/arbiter for one 32x8 dcache data bank: shares the bank RAM's
// write and read ports between CPU byte accesses, line fills and line flushes.
module dcache_bank_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_wr_req,
  input  logic [4:0] cpu_wr_addr,
  input  logic [7:0] cpu_wr_data,
  output logic       cpu_wr_ack,
  input  logic       cpu_rd_req,
  input  logic [4:0] cpu_rd_addr,
  output logic [7:0] cpu_rd_data,
  output logic       cpu_rd_valid,
  input  logic       fill_start,
  input  logic       fill_valid,
  input  logic [7:0] fill_data,
  output logic       fill_ready,
  output logic       fill_done,
  input  logic       flush_start,
  output logic       flush_valid,
  output logic [7:0] flush_data,
  input  logic       flush_ready,
  output logic       flush_done,
  output logic       busy,
  output logic [4:0] ram_raddr,
  input  logic [7:0] ram_dataout,
  output logic [4:0] ram_waddr,
  output logic [7:0] ram_datain,
  output logic       ram_we
);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q;
  logic       all_ld_q;
  logic       fill_pend_q;

  logic rd_serve;
  logic fl_load;
  logic fl_accept;
  logic fl_exit;

  assign busy = (state_q != IDLE) || fill_pend_q;

  always_comb begin
    state_d    = state_q;
    cpu_wr_ack = 1'b0;
    fill_ready = 1'b0;
    ram_raddr  = 5'd0;
    ram_waddr  = 5'd0;
    ram_datain = 8'd0;
    ram_we     = 1'b0;
    rd_serve   = 1'b0;
    fl_load    = 1'b0;
    fl_accept  = 1'b0;
    fl_exit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_start)     state_d = FLUSH;
        else if (fill_start) state_d = FILL;
        // Any start outranks a CPU write in the same cycle.
        if (cpu_wr_req && !fill_start && !flush_start && !fill_pend_q) begin
          cpu_wr_ack = 1'b1;
          ram_we     = 1'b1;
          ram_waddr  = cpu_wr_addr;
          ram_datain = cpu_wr_data;
        end
        rd_serve = cpu_rd_req && !cpu_rd_valid;
      end
      FILL: begin
        fill_ready = 1'b1;
        rd_serve   = cpu_rd_req && !cpu_rd_valid;
        if (fill_valid) begin
          ram_we     = 1'b1;
          ram_waddr  = cnt_q;
          ram_datain = fill_data;
          if (cnt_q == 5'd31) state_d = IDLE;
        end
      end
      FLUSH: begin
        ram_raddr = cnt_q;
        fl_load   = (!flush_valid || flush_ready) && !all_ld_q;
        fl_accept = flush_valid && flush_ready;
        // Loading stops after byte 31, so an accept with all bytes loaded is the last one.
        if (fl_accept && all_ld_q) begin
          fl_exit = 1'b1;
          state_d = (fill_pend_q || fill_start) ? FILL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rd_serve) ram_raddr = cpu_rd_addr;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 5'd0;
      all_ld_q     <= 1'b0;
      fill_pend_q  <= 1'b0;
      cpu_rd_valid <= 1'b0;
      cpu_rd_data  <= 8'd0;
      flush_valid  <= 1'b0;
      flush_data   <= 8'd0;
      fill_done    <= 1'b0;
      flush_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_done    <= 1'b0;
      flush_done   <= 1'b0;
      cpu_rd_valid <= rd_serve;
      if (rd_serve) cpu_rd_data <= ram_dataout;
      case (state_q)
        IDLE: begin
          if (flush_start) begin
            cnt_q       <= 5'd0;
            all_ld_q    <= 1'b0;
            fill_pend_q <= fill_start;
          end else if (fill_start) begin
            cnt_q <= 5'd0;
          end
        end
        FILL: begin
          if (fill_valid) begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) fill_done <= 1'b1;
          end
        end
        FLUSH: begin
          if (fill_start) fill_pend_q <= 1'b1;
          if (fl_load) begin
            flush_data  <= ram_dataout;
            flush_valid <= 1'b1;
            cnt_q       <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) all_ld_q <= 1'b1;
          end else if (fl_accept) begin
            flush_valid <= 1'b0;
          end
          if (fl_exit) begin
            flush_done  <= 1'b1;
            fill_pend_q <= 1'b0;
            all_ld_q    <= 1'b0;
            cnt_q       <= 5'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_bank_ctrl.sv
// Directed bench for dcache_bank_ctrl with a behavioural 32x8 bank RAM.
module tb_dcache_bank_ctrl;

  logic       clk;
  logic       reset_n;
  logic       cpu_wr_req;
  logic [4:0] cpu_wr_addr;
  logic [7:0] cpu_wr_data;
  logic       cpu_wr_ack;
  logic       cpu_rd_req;
  logic [4:0] cpu_rd_addr;
  logic [7:0] cpu_rd_data;
  logic       cpu_rd_valid;
  logic       fill_start;
  logic       fill_valid;
  logic [7:0] fill_data;
  logic       fill_ready;
  logic       fill_done;
  logic       flush_start;
  logic       flush_valid;
  logic [7:0] flush_data;
  logic       flush_ready;
  logic       flush_done;
  logic       busy;
  logic [4:0] ram_raddr;
  logic [7:0] ram_dataout;
  logic [4:0] ram_waddr;
  logic [7:0] ram_datain;
  logic       ram_we;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [32];

  dcache_bank_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_wr_ack(cpu_wr_ack),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_data(cpu_rd_data),
    .cpu_rd_valid(cpu_rd_valid),
    .fill_start(fill_start), .fill_valid(fill_valid), .fill_data(fill_data),
    .fill_ready(fill_ready), .fill_done(fill_done),
    .flush_start(flush_start), .flush_valid(flush_valid), .flush_data(flush_data),
    .flush_ready(flush_ready), .flush_done(flush_done),
    .busy(busy),
    .ram_raddr(ram_raddr), .ram_dataout(ram_dataout), .ram_waddr(ram_waddr),
    .ram_datain(ram_datain), .ram_we(ram_we)
  );

  // Bank RAM: async read, sync write
  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_datain;
  assign ram_dataout = mem[ram_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    cpu_wr_req = 1'b1; cpu_wr_addr = a; cpu_wr_data = d;
    #1;
    check("cpu_wr_ack", {31'd0, cpu_wr_ack}, 32'd1);
    step();
    cpu_wr_req = 1'b0;
  endtask

  initial begin
    int k;
    int cyc;
    reset_n = 1'b0; cpu_wr_req = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
    cpu_rd_req = 1'b0; cpu_rd_addr = '0; fill_start = 1'b0; fill_valid = 1'b0;
    fill_data = '0; flush_start = 1'b0; flush_ready = 1'b0;
    step(); step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rd_valid", {31'd0, cpu_rd_valid}, 32'd0);
    check("rst_rd_data", {24'd0, cpu_rd_data}, 32'd0);
    check("rst_flush_valid", {31'd0, flush_valid}, 32'd0);
    check("rst_flush_data", {24'd0, flush_data}, 32'd0);
    check("rst_dones", {30'd0, fill_done, flush_done}, 32'd0);
    check("rst_fill_ready", {31'd0, fill_ready}, 32'd0);
    reset_n = 1'b1;
    step();

    // CPU write then read
    cpu_wr_req = 1'b1; cpu_wr_addr = 5'd7; cpu_wr_data = 8'hA5;
    #1;
    check("wr_ack", {31'd0, cpu_wr_ack}, 32'd1);
    check("wr_ram", {18'd0, ram_we, ram_waddr, ram_datain}, {18'd0, 1'b1, 5'd7, 8'hA5});
    step();
    cpu_wr_req = 1'b0;
    cpu_rd_req = 1'b1; cpu_rd_addr = 5'd7;
    #1;
    check("rd_raddr", {27'd0, ram_raddr}, 32'd7);
    check("rd_valid_early", {31'd0, cpu_rd_valid}, 32'd0);
    step();
    check("rd_valid", {31'd0, cpu_rd_valid}, 32'd1);
    check("rd_data", {24'd0, cpu_rd_data}, 32'hA5);
    cpu_rd_req = 1'b0;
    step();
    check("rd_valid_pulse", {31'd0, cpu_rd_valid}, 32'd0);

    // Same-address read and write: read sees old value
    cpu_wr_req = 1'b1; cpu_wr_addr = 5'd7; cpu_wr_data = 8'h5A;
    cpu_rd_req = 1'b1; cpu_rd_addr = 5'd7;
    step();
    cpu_wr_req = 1'b0; cpu_rd_req = 1'b0;
    check("rw_same_old", {24'd0, cpu_rd_data}, 32'hA5);
    check("rw_same_mem", {24'd0, mem[7]}, 32'h5A);

    // Fill with fill_valid toggling
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    check("fill_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      fill_valid = 1'b0;
      #1;
      check("fill_ready_idle", {31'd0, fill_ready}, 32'd1);
      check("fill_we_idle", {31'd0, ram_we}, 32'd0);
      step();
      fill_valid = 1'b1; fill_data = 8'(i);
      #1;
      check("fill_ready", {31'd0, fill_ready}, 32'd1);
      check("fill_waddr", {26'd0, ram_we, ram_waddr}, {26'd0, 1'b1, 5'(i)});
      check("fill_done_early", {31'd0, fill_done}, 32'd0);
      step();
    end
    fill_valid = 1'b0;
    check("fill_done", {31'd0, fill_done}, 32'd1);
    check("fill_busy_end", {31'd0, busy}, 32'd0);
    step();
    check("fill_done_pulse", {31'd0, fill_done}, 32'd0);
    for (int i = 0; i < 32; i += 5) check("fill_mem", {24'd0, mem[i]}, i);

    // Preload RAM[i] = 0xFF - i through CPU writes
    for (int i = 0; i < 32; i++) cpu_write(5'(i), 8'(255 - i));

    // Flush with random flush_ready
    flush_start = 1'b1;
    step();
    flush_start = 1'b0;
    check("flush_valid_t1", {31'd0, flush_valid}, 32'd0);
    check("flush_raddr_t1", {27'd0, ram_raddr}, 32'd0);
    k = 0;
    cyc = 0;
    while (k < 32 && cyc < 400) begin
      flush_ready = 1'($urandom_range(0, 1));
      #1;
      check("flush_done_early", {31'd0, flush_done}, 32'd0);
      if (flush_valid && flush_ready) begin
        check("flush_byte", {24'd0, flush_data}, 32'(255 - k));
        k++;
      end
      step();
      cyc++;
    end
    flush_ready = 1'b0;
    check("flush_count", k, 32);
    check("flush_done", {31'd0, flush_done}, 32'd1);
    check("flush_valid_end", {31'd0, flush_valid}, 32'd0);
    step();
    check("flush_done_pulse", {31'd0, flush_done}, 32'd0);
    check("flush_idle", {31'd0, busy}, 32'd0);

    // Simultaneous starts with a held CPU write
    cpu_wr_req = 1'b1; cpu_wr_addr = 5'd9; cpu_wr_data = 8'h99;
    flush_start = 1'b1; fill_start = 1'b1; flush_ready = 1'b1;
    #1;
    check("both_ack_start", {31'd0, cpu_wr_ack}, 32'd0);
    step();
    flush_start = 1'b0; fill_start = 1'b0;
    check("both_fv_t1", {31'd0, flush_valid}, 32'd0);
    check("both_ack_t1", {31'd0, cpu_wr_ack}, 32'd0);
    step();
    for (int i = 0; i < 32; i++) begin
      check("both_fv", {31'd0, flush_valid}, 32'd1);
      check("both_fdata", {24'd0, flush_data}, 32'(255 - i));
      check("both_ack_fl", {31'd0, cpu_wr_ack}, 32'd0);
      step();
    end
    flush_ready = 1'b0;
    check("both_flush_done", {31'd0, flush_done}, 32'd1);
    check("both_fill_ready", {31'd0, fill_ready}, 32'd1);
    check("both_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      fill_valid = 1'b1; fill_data = 8'(8'h80 + i);
      #1;
      check("both_fill_waddr", {27'd0, ram_waddr}, 32'(i));
      check("both_ack_fi", {31'd0, cpu_wr_ack}, 32'd0);
      step();
    end
    fill_valid = 1'b0;
    #1;
    check("both_fill_done", {31'd0, fill_done}, 32'd1);
    check("both_ack_late", {31'd0, cpu_wr_ack}, 32'd1);
    check("both_ack_addr", {27'd0, ram_waddr}, 32'd9);
    step();
    cpu_wr_req = 1'b0;
    check("both_mem9", {24'd0, mem[9]}, 32'h99);
    check("both_mem0", {24'd0, mem[0]}, 32'h80);

    // Reset in the middle of a fill
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      fill_valid = 1'b1; fill_data = 8'(8'h40 + i);
      step();
    end
    fill_valid = 1'b0;
    reset_n = 1'b0;
    step();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, fill_ready}, 32'd0);
    check("mid_rst_dones", {30'd0, fill_done, flush_done}, 32'd0);
    check("mid_rst_mem", {24'd0, mem[9]}, 32'h49);
    reset_n = 1'b1;
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    fill_valid = 1'b1; fill_data = 8'h11;
    #1;
    check("refill_addr", {26'd0, ram_we, ram_waddr}, {26'd0, 1'b1, 5'd0});
    step();
    fill_valid = 1'b0;
    check("refill_mem", {24'd0, mem[0]}, 32'h11);
    reset_n = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_bank_ctrl.md
# dcache_bank_ctrl

Sequencer and port arbiter for one 32-entry × 8-bit data-cache bank built on the dual-port byte RAM (async read, sync write). It shares the bank's single write port and single read port between CPU byte accesses, a 32-byte line-fill stream from memory and a 32-byte write-back (flush) stream to memory. One instance sits beside each byte bank of the dcache data array.

## Interface
Parameters:
- none; depth 32 (5-bit address) and 8-bit data are fixed by the bank RAM.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  synchronous, active-low reset
- cpu_wr_req  in  1  CPU byte-write request, held until acked
- cpu_wr_addr  in  5  CPU write address
- cpu_wr_data  in  8  CPU write data
- cpu_wr_ack  out  1  combinational; write committed at this clock edge
- cpu_rd_req  in  1  CPU read request, held until cpu_rd_valid
- cpu_rd_addr  in  5  CPU read address
- cpu_rd_data  out  8  registered read data
- cpu_rd_valid  out  1  one-cycle pulse; cpu_rd_data valid
- fill_start  in  1  one-cycle pulse; begin a 32-byte line fill
- fill_valid  in  1  fill byte present
- fill_data  in  8  fill byte
- fill_ready  out  1  controller accepts fill byte
- fill_done  out  1  one-cycle pulse after 32nd fill byte written
- flush_start  in  1  one-cycle pulse; begin a 32-byte write-back
- flush_valid  out  1  registered; flush_data valid
- flush_data  out  8  registered write-back byte
- flush_ready  in  1  downstream accepts flush byte
- flush_done  out  1  one-cycle pulse after 32nd byte accepted
- busy  out  1  state != IDLE or fill pending
- ram_raddr  out  5  to bank RAM read address
- ram_dataout  in  8  from bank RAM (combinational read)
- ram_waddr  out  5  to bank RAM write address
- ram_datain  out  8  to bank RAM write data
- ram_we  out  1  to bank RAM write enable

## Operation
- States: IDLE, FILL, FLUSH. 5-bit byte counter cnt plus a loaded-count for flush; 1-bit fill_pending.
- IDLE: flush_start → FLUSH (priority); fill_start alone → FILL; both in same cycle → FLUSH with fill_pending=1. FLUSH exit with fill_pending → FILL directly (pending cleared), else IDLE.
- Starts outrank CPU: in a cycle with any start, or with fill_pending set, CPU write not acked.
- CPU write: served only in IDLE; ram_we=1, ram_waddr=cpu_wr_addr, ram_datain=cpu_wr_data, cpu_wr_ack=1, same cycle.
- CPU read: served in IDLE and FILL; ram_raddr=cpu_rd_addr, cpu_rd_data<=ram_dataout, cpu_rd_valid=1 next cycle. Not served in FLUSH (read port owned by flush); requester holds.
- FILL: fill_ready=1; on fill_valid: ram_we=1, ram_waddr=cnt, ram_datain=fill_data, cnt++. After write at cnt=31: cnt wraps to 0, fill_done pulses next cycle, state → IDLE. CPU writes stalled throughout.
- FLUSH: ram_raddr=cnt. Output register loads ram_dataout when !flush_valid || flush_ready, while fewer than 32 bytes loaded; cnt++ per load. After byte 31 accepted (flush_valid && flush_ready): flush_valid=0, flush_done pulses next cycle, state exits. CPU reads and writes stalled.
- fill_start during FILL or FLUSH-with-pending, flush_start outside IDLE: ignored.
- Default ram_* outputs when not driven: ram_we=0, addresses/data 0.

## Timing
- Reset (reset_n=0 at edge): state IDLE, cnt 0, fill_pending 0, cpu_rd_valid 0, cpu_rd_data 0, flush_valid 0, flush_data 0, fill_done 0, flush_done 0, busy 0. Applies mid-FILL/FLUSH; RAM contents untouched.
- CPU write: 0-cycle ack. CPU read: 1-cycle latency.
- Fill: start at T → fill_ready from T+1; 32 back-to-back bytes → fill_done at T+33.
- Flush: start at T → first flush_valid at T+2; with flush_ready=1 continuously, bytes T+2..T+33, flush_done at T+34.
- Same-address CPU read and write in one IDLE cycle: read returns pre-write value.
- fill_valid low / flush_ready low: hold cnt and output register; no bytes dropped or duplicated.

## Test plan
- CPU write 0xA5 to addr 7 in IDLE, then read addr 7 → ack same cycle; cpu_rd_valid one cycle after request with 0xA5.
- fill_start, bytes 0x00..0x1F with fill_valid toggling every other cycle → RAM[i]=i, fill_done once after byte 31, ready stays high in FILL.
- Preload RAM[i]=0xFF-i, flush_start, flush_ready random 50% → 32 bytes 0xFF..0xE0 in order, none repeated, flush_done once.
- flush_start and fill_start same cycle, CPU write held → flush completes, FILL entered without IDLE gap, CPU write acked only after fill_done.
- reset_n low at fill byte 10 → all outputs to reset values next edge; new fill_start writes from address 0.
